pipo_shift_register: RTL and testbench



---
 rtl/pipo_shift_register.sv | 44 ++++
 tb/tb_pipo_shift_register.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pipo_shift_register.sv
// pipo_shift_register: byte-wide load/clear/shift of the parallel input into a
// fully registered output. Shifts act on the incoming data, never on y.
module pipo_shift_register #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] y
);

   localparam logic [1:0] ModeLoad  = 2'b00;
   localparam logic [1:0] ModeClear = 2'b01;
   localparam logic [1:0] ModeShr   = 2'b10;
   localparam logic [1:0] ModeShl   = 2'b11;

   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] w_y_next;

   // Next-state selection; illegal (X/Z) mode falls into the clearing default.
   always_comb begin
      w_y_next = '0;
      case (mode)
         ModeLoad:  w_y_next = data;
         ModeClear: w_y_next = '0;
         ModeShr:   w_y_next = {1'b0, data[WIDTH-1:1]};
         ModeShl:   w_y_next = {data[WIDTH-2:0], 1'b0};
         default:   w_y_next = '0;
      endcase
   end

   // Output register; reset clears immediately and overrides every mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y <= '0;
      end else begin
         r_y <= w_y_next;
      end
   end

   assign y = r_y;

endmodule

// File: tb/tb_pipo_shift_register.sv
// Self-checking bench for pipo_shift_register: directed table, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_pipo_shift_register;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic [1:0]       mode;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] y;

   int checks;
   int errors;

   typedef struct {
      logic [1:0]       mode;
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   pipo_shift_register #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode),
      .data  (data),
      .y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: operation rules expressed as plain arithmetic.
   function automatic logic [WIDTH-1:0] model(input logic [1:0] m, input logic [WIDTH-1:0] d);
      int unsigned v;
      v = int'(d);
      case (m)
         2'd0:    return WIDTH'(v);
         2'd1:    return '0;
         2'd2:    return WIDTH'(v / 2);
         default: return WIDTH'((v * 2) % (1 << WIDTH));
      endcase
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs at the falling edge, then sample just after the rising edge.
   task automatic apply(input logic [1:0] m, input logic [WIDTH-1:0] d);
      @(negedge clk);
      mode = m;
      data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0]       rm;
      logic [WIDTH-1:0] rd;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      mode   = 2'b00;
      data   = 8'hAB;

      // Reset holds y at zero across clock edges.
      #2;
      check("reset_async", y, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold", y, 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release_load", y, 8'hAB);

      // Directed table.
      for (int i = 0; i < 4; i++) vecs.push_back('{2'b00, 8'b10101011, 8'b10101011});
      vecs.push_back('{2'b00, 8'h5C, 8'h5C});
      vecs.push_back('{2'b00, 8'hAB, 8'hAB});
      for (int i = 0; i < 4; i++) vecs.push_back('{2'b01, 8'b10101011, 8'h00});
      for (int i = 0; i < 4; i++) vecs.push_back('{2'b10, 8'b10101011, 8'b01010101});
      vecs.push_back('{2'b10, 8'h80, 8'h40});
      vecs.push_back('{2'b10, 8'h01, 8'h00});
      for (int i = 0; i < 4; i++) vecs.push_back('{2'b11, 8'b10101011, 8'b01010110});
      vecs.push_back('{2'b11, 8'h80, 8'h00});
      vecs.push_back('{2'b11, 8'hFF, 8'hFE});
      vecs.push_back('{2'b10, 8'hFF, 8'h7F});
      vecs.push_back('{2'b11, 8'h01, 8'h02});
      foreach (vecs[i]) begin
         apply(vecs[i].mode, vecs[i].data);
         check($sformatf("vec%0d_mode%0d", i, vecs[i].mode), y, vecs[i].exp);
      end

      // Async reset pulse between edges while shifting left.
      apply(2'b11, 8'hFF);
      check("pre_async_shl", y, 8'hFE);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_drop", y, 8'h00);
      @(negedge clk);
      check("async_reset_still_low", y, 8'h00);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_async_shl", y, 8'hFE);

      // Mid-cycle input change must not reach y before the next edge.
      @(negedge clk);
      mode = 2'b00;
      data = 8'h3C;
      #1;
      check("no_comb_path", y, 8'hFE);
      @(posedge clk);
      #1;
      check("comb_path_load", y, 8'h3C);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 300; i++) begin
         rm = 2'($urandom_range(0, 3));
         rd = WIDTH'($urandom);
         apply(rm, rd);
         check($sformatf("rand%0d_mode%0d_data%h", i, rm, rd), y, model(rm, rd));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
